// File: rtl/hilo_muldiv_ctrl_pkg.sv
// rtl/hilo_muldiv_ctrl_pkg.sv - shared op/state types and op-class helpers for the HI/LO sequencer
package hilo_muldiv_ctrl_pkg;

    localparam int HILO_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MADD  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MSUB  = 4'd7,
        OP_MSUBU = 4'd8,
        OP_MTHI  = 4'd9,
        OP_MTLO  = 4'd10
    } hilo_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } hilo_state_t;

    function automatic logic op_legal(input hilo_op_t op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU,
                          OP_MSUB, OP_MSUBU, OP_MTHI, OP_MTLO};
    endfunction

    function automatic logic is_mul(input hilo_op_t op);
        return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic is_div(input hilo_op_t op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_signed(input hilo_op_t op);
        return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    endfunction

    function automatic logic is_madd(input hilo_op_t op);
        return op inside {OP_MADD, OP_MADDU};
    endfunction

    function automatic logic is_msub(input hilo_op_t op);
        return op inside {OP_MSUB, OP_MSUBU};
    endfunction

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - radix-2 restoring divider, one quotient bit per cycle on operand magnitudes
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             abort,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             busy;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] q_r, r_r, d_r;
    logic             neg_q, neg_r;
    logic [WIDTH:0]   shifted, diff;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    assign shifted = {r_r, q_r[WIDTH-1]};
    assign diff    = shifted - {1'b0, d_r};
    assign done    = busy && (count == CW'(1));

    // Results hold once busy drops, so the controller can read them in its write cycle
    assign quot = neg_q ? -q_r : q_r;
    assign rem  = neg_r ? -r_r : r_r;

    always_ff @(posedge clk) begin
        if (abort) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= CW'(WIDTH);
            q_r   <= mag(dividend, signed_op);
            d_r   <= mag(divisor, signed_op);
            r_r   <= '0;
            neg_q <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= signed_op && dividend[WIDTH-1];
        end else if (busy) begin
            if (!diff[WIDTH]) begin
                r_r <= diff[WIDTH-1:0];
                q_r <= {q_r[WIDTH-2:0], 1'b1};
            end else begin
                r_r <= shifted[WIDTH-1:0];
                q_r <= {q_r[WIDTH-2:0], 1'b0};
            end
            count <= count - CW'(1);
            if (count == CW'(1)) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - EX-stage sequencer for every HI/LO-writing instruction
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH   = HILO_WIDTH,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] hi_rd,
    input  logic [WIDTH-1:0] lo_rd,
    input  logic             flush,
    output logic             stall_o,
    output logic             busy_o,
    output logic             we_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int W2 = 2 * WIDTH;

    hilo_op_t         op_in;
    hilo_state_t      state, state_nx;
    logic             accept, div_zero, div_start, div_done, div_abort;
    logic [WIDTH-1:0] div_quot, div_rem;
    logic [7:0]       cnt;
    logic             from_mul, from_div;
    logic [WIDTH-1:0] res_hi, res_lo, last_hi, last_lo, wr_hi, wr_lo;
    logic             sgn;
    logic [W2-1:0]    a_x, b_x, prod, mul_val;
    logic [W2-1:0]    mul_pipe [MUL_LAT];

    assign op_in     = hilo_op_t'(op);
    assign div_zero  = (src_b == '0);
    assign accept    = (state == ST_IDLE) && op_valid && !flush && op_legal(op_in);
    assign div_start = accept && is_div(op_in) && !div_zero;
    assign div_abort = rst || flush;

    // Low 2*WIDTH bits of the extended-operand product are exact for both signednesses
    always_comb begin
        sgn  = is_signed(op_in);
        a_x  = {{WIDTH{sgn & src_a[WIDTH-1]}}, src_a};
        b_x  = {{WIDTH{sgn & src_b[WIDTH-1]}}, src_b};
        prod = a_x * b_x;
        if (is_madd(op_in))      mul_val = {hi_rd, lo_rd} + prod;
        else if (is_msub(op_in)) mul_val = {hi_rd, lo_rd} - prod;
        else                     mul_val = prod;
    end

    always_comb begin
        state_nx = state;
        stall_o  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul(op_in)) begin
                        state_nx = (MUL_LAT == 1) ? ST_DONE : ST_MUL;
                        stall_o  = 1'b1;
                    end else if (is_div(op_in) && !div_zero) begin
                        state_nx = ST_DIV;
                        stall_o  = 1'b1;
                    end else begin
                        state_nx = ST_DONE;
                    end
                end
            end
            ST_MUL: begin
                stall_o = 1'b1;
                if (flush)                          state_nx = ST_IDLE;
                else if (cnt == 8'(MUL_LAT - 2))    state_nx = ST_DONE;
            end
            ST_DIV: begin
                stall_o = 1'b1;
                if (flush)         state_nx = ST_IDLE;
                else if (div_done) state_nx = ST_DONE;
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    assign busy_o = (state != ST_IDLE);
    assign we_o   = (state == ST_DONE) && !flush;
    assign wr_hi  = from_mul ? mul_pipe[MUL_LAT-1][W2-1:WIDTH] : (from_div ? div_rem  : res_hi);
    assign wr_lo  = from_mul ? mul_pipe[MUL_LAT-1][WIDTH-1:0]  : (from_div ? div_quot : res_lo);
    assign hi_o   = we_o ? wr_hi : last_hi;
    assign lo_o   = we_o ? wr_lo : last_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            last_hi  <= '0;
            last_lo  <= '0;
            from_mul <= 1'b0;
            from_div <= 1'b0;
            res_hi   <= '0;
            res_lo   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= (state == ST_MUL) ? cnt + 8'd1 : 8'd0;
            last_hi <= hi_o;
            last_lo <= lo_o;
            if (accept) begin
                from_mul <= is_mul(op_in);
                from_div <= is_div(op_in) && !div_zero;
                // MTHI and divide-by-zero both put src_a in HI
                res_hi   <= (op_in == OP_MTLO) ? hi_rd : src_a;
                res_lo   <= (op_in == OP_MTHI) ? lo_rd : ((op_in == OP_MTLO) ? src_a : '1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mul_pipe[0] <= mul_val;
        for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
    end

    div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .start     (div_start),
        .signed_op (is_signed(op_in)),
        .dividend  (src_a),
        .divisor   (src_b),
        .abort     (div_abort),
        .done      (div_done),
        .quot      (div_quot),
        .rem       (div_rem)
    );

endmodule
